threshold_simd: RTL and testbench
=================================

THRESHOLD_SIMD -- requirements
Module: threshold_simd

Interface
REQ-001 The module SHALL have parameter PIX_W, default 8, meaning bits per pixel.
REQ-002 The module SHALL have parameter LANES, default 4, meaning pixels processed per cycle.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 The module SHALL have port start, input, 1 bit; input-valid qualifier for pixels_in in the same cycle.
REQ-006 The module SHALL have port pixels_in, input, LANES*PIX_W bits (32 at defaults); lane k occupies bits [k*PIX_W +: PIX_W], with lane 0 at the LSBs and lane 0 as the leftmost image pixel of the group.
REQ-007 The module SHALL have port threshold, input, PIX_W bits; unsigned compare level, one value shared by all lanes.
REQ-008 The module SHALL have port pixels_out, output, LANES*PIX_W bits; binarised pixels with the same lane packing as pixels_in.
REQ-009 The module SHALL have port done, output, 1 bit; high when pixels_out holds a result for a start-qualified input.

Function
REQ-010 Per lane, result SHALL be all-ones (8'hFF) when pixel >= threshold (unsigned), else all-zeros.
REQ-011 Lanes SHALL be fully independent; no cross-lane carry or interaction.
REQ-012 Latency SHALL be exactly 1 cycle: pixels_in/threshold sampled at rising edge N with start=1 appear on pixels_out after edge N, with done=1 during the cycle following edge N.
REQ-013 Throughput SHALL be one LANES-pixel word per cycle while start is held high; no backpressure and no stall.
REQ-014 At an edge where start=0, done SHALL go 0, and pixels_out SHALL hold its previous value.
REQ-015 done SHALL be the registered value of start; there are no other states besides the valid register.
REQ-016 threshold SHALL be sampled with the data at the same edge; a threshold change takes effect on the word sampled at that edge.
REQ-017 Boundary: threshold=0 SHALL yield all lanes 8'hFF for any input.
REQ-018 Boundary: threshold=8'hFF SHALL yield 8'hFF only for pixels equal to 8'hFF.
REQ-019 Boundary: a pixel equal to threshold SHALL yield 8'hFF.
REQ-020 X/unknown on pixels_in while start=0 SHALL NOT propagate to pixels_out.

Reset
REQ-021 While rst_n=0, pixels_out SHALL be 0 and done SHALL be 0, asynchronously.
REQ-022 Reset asserted mid-stream SHALL discard the in-flight word.
REQ-023 After rst_n deasserts, the first edge with start=1 SHALL produce a valid result on the following cycle.

Structure
REQ-024 Shared package threshold_pkg SHALL hold PIX_W default, PIX_MAX (all-ones) and PIX_MIN (zero) constants.
REQ-025 One sub-module threshold_scalar (clk, rst_n, start, pixel_in, threshold, pixel_out, done) SHALL implement a single lane with identical timing.
REQ-026 threshold_simd SHALL instantiate LANES copies of threshold_scalar via generate and take done from lane 0.
REQ-027 threshold_scalar SHALL be usable standalone; it is equivalent to threshold_simd with LANES=1.

Verification
REQ-028 Reset: rst_n=0 with start=1, pixels_in=32'hFFFFFFFF -> pixels_out=0, done=0.
REQ-029 Mixed lanes: threshold=128, pixels_in=32'h7F80_00FF, start=1 -> next cycle pixels_out=32'h00FF_00FF, done=1.
REQ-030 Extremes: threshold=0 with any input -> 32'hFFFFFFFF; threshold=255 with 32'hFEFF_FE00 -> 32'h00FF_0000.
REQ-031 Streaming: 64x64 image, 1024 back-to-back words at threshold 128 -> every output word equals the per-lane reference model, one cycle late, with no gaps in done.
REQ-032 Hold/idle: start dropped for 3 cycles -> done=0 and pixels_out unchanged; resuming start gives a correct result on the next cycle.
REQ-033 Scalar equivalence: the same image fed per pixel to threshold_scalar -> output bit-identical to the SIMD output.

Source files
------------

// File: rtl/threshold_pkg.sv
// threshold_pkg: shared pixel width default and binarisation levels.
// Imported by threshold_scalar and threshold_simd.
package threshold_pkg;

    localparam int PIX_W_DEF = 8;

    typedef logic [PIX_W_DEF-1:0] pix_t;

    localparam pix_t PIX_MAX = '1;
    localparam pix_t PIX_MIN = '0;

    // Binarise one pixel against a level (default width).
    function automatic pix_t binarise(input pix_t p, input pix_t t);
        return (p >= t) ? PIX_MAX : PIX_MIN;
    endfunction

endpackage

// File: rtl/threshold_scalar.sv
// threshold_scalar: one-lane registered binariser, 1-cycle latency.
// Ports: clk, rst_n (async low), start (valid), pixel_in, threshold,
//        pixel_out (all-ones if pixel_in >= threshold, else 0), done.
module threshold_scalar
    import threshold_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic [PIX_W-1:0] threshold,
    output logic [PIX_W-1:0] pixel_out,
    output logic             done
);

    logic             hit;
    logic [PIX_W-1:0] level;

    assign hit   = (pixel_in >= threshold);
    assign level = hit ? {PIX_W{1'b1}} : {PIX_W{1'b0}};

    // Output only loads on start, so idle-cycle X on pixel_in
    // never reaches pixel_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out <= '0;
            done      <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                pixel_out <= level;
            end
        end
    end

endmodule

// File: rtl/threshold_simd.sv
// threshold_simd: LANES independent threshold_scalar lanes.
// Ports: clk, rst_n, start, pixels_in/pixels_out (lane k at
//        [k*PIX_W +: PIX_W]), threshold (shared), done (lane 0).
module threshold_simd
    import threshold_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LANES*PIX_W-1:0] pixels_in,
    input  logic [PIX_W-1:0]       threshold,
    output logic [LANES*PIX_W-1:0] pixels_out,
    output logic                   done
);

    logic [LANES-1:0] lane_done;
    logic             unused_done;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        threshold_scalar #(
            .PIX_W (PIX_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .pixel_in  (pixels_in[k*PIX_W +: PIX_W]),
            .threshold (threshold),
            .pixel_out (pixels_out[k*PIX_W +: PIX_W]),
            .done      (lane_done[k])
        );
    end

    // All lanes share start, so their done flags are identical.
    assign done        = lane_done[0];
    assign unused_done = ^lane_done;

endmodule

// File: tb/tb_threshold_simd.sv
// tb_threshold_simd: randomized self-checking bench for threshold_simd
// and threshold_scalar against a per-lane arithmetic reference.
module tb_threshold_simd;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] pixels_in;
    logic [7:0]  threshold;
    logic [31:0] pixels_out;
    logic        done;

    logic        s_start;
    logic [7:0]  s_pix;
    logic [7:0]  s_thr;
    logic [7:0]  s_out;
    logic        s_done;

    int n_chk;
    int n_fail;

    logic [31:0] img  [1024];
    logic [31:0] sres [1024];

    threshold_simd #(
        .PIX_W (8),
        .LANES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pixels_in  (pixels_in),
        .threshold  (threshold),
        .pixels_out (pixels_out),
        .done       (done)
    );

    threshold_scalar #(
        .PIX_W (8)
    ) sdut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s_start),
        .pixel_in  (s_pix),
        .threshold (s_thr),
        .pixel_out (s_out),
        .done      (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each byte independently, >= threshold -> 255 else 0.
    function automatic logic [31:0] ref_word(input logic [31:0] w,
                                             input int thr);
        logic [31:0] r;
        r = 0;
        for (int k = 0; k < 4; k++) begin
            int p;
            p = (w >> (8 * k)) % 256;
            if (p >= thr) r = r + (32'd255 << (8 * k));
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] w;
        int          t;
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b1;
        pixels_in = 32'hFFFF_FFFF;
        threshold = 8'd0;
        s_start   = 1'b0;
        s_pix     = 8'd0;
        s_thr     = 8'd0;

        // Reset holds outputs low even with start active.
        tick();
        chk("reset_out", pixels_out, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        tick();
        chk("reset_out2", pixels_out, 32'h0);
        chk("reset_sdone", {31'b0, s_done}, 32'h0);

        // First start after reset release.
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_done", {31'b0, done}, 32'h0);
        threshold = 8'd128;
        pixels_in = 32'h7F80_00FF;
        start     = 1'b1;
        tick();
        chk("mixed_out", pixels_out, 32'h00FF_00FF);
        chk("mixed_done", {31'b0, done}, 32'h1);

        // Extremes.
        threshold = 8'd0;
        pixels_in = $urandom;
        tick();
        chk("thr0_out", pixels_out, 32'hFFFF_FFFF);
        threshold = 8'd255;
        pixels_in = 32'hFEFF_FE00;
        tick();
        chk("thr255_out", pixels_out, 32'h00FF_0000);
        threshold = 8'h5A;
        pixels_in = 32'h5A59_005A;
        tick();
        chk("equal_out", pixels_out, 32'hFF00_00FF);

        // Per-word threshold changes.
        for (int i = 0; i < 32; i++) begin
            w = $urandom;
            t = int'($urandom_range(0, 255));
            pixels_in = w;
            threshold = 8'(t);
            tick();
            chk("rthr_out", pixels_out, ref_word(w, t));
            chk("rthr_done", {31'b0, done}, 32'h1);
        end

        // Hold/idle with X data on the input.
        prev      = pixels_out;
        start     = 1'b0;
        pixels_in = 'x;
        threshold = 'x;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_out", pixels_out, prev);
            chk("hold_done", {31'b0, done}, 32'h0);
        end
        w         = $urandom;
        pixels_in = w;
        threshold = 8'd77;
        start     = 1'b1;
        tick();
        chk("resume_out", pixels_out, ref_word(w, 77));
        chk("resume_done", {31'b0, done}, 32'h1);

        // Streaming 64x64 image at threshold 128.
        for (int i = 0; i < 1024; i++) img[i] = $urandom;
        threshold = 8'd128;
        for (int i = 0; i < 1024; i++) begin
            pixels_in = img[i];
            tick();
            sres[i] = pixels_out;
            chk("stream_out", pixels_out, ref_word(img[i], 128));
            chk("stream_done", {31'b0, done}, 32'h1);
        end

        // Async reset mid-stream discards the in-flight word.
        pixels_in = 32'hFFFF_FFFF;
        threshold = 8'd0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_out", pixels_out, 32'h0);
        chk("async_done", {31'b0, done}, 32'h0);
        tick();
        chk("async_hold", pixels_out, 32'h0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Scalar lane fed the same image pixel by pixel.
        s_thr   = 8'd128;
        s_start = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            for (int k = 0; k < 4; k++) begin
                s_pix = img[i][8*k +: 8];
                tick();
                chk("scalar_eq", {24'b0, s_out},
                    {24'b0, sres[i][8*k +: 8]});
            end
        end
        chk("scalar_done", {31'b0, s_done}, 32'h1);
        s_start = 1'b0;
        tick();
        chk("scalar_idle", {31'b0, s_done}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
